pll_rst_seq: RTL
================

Name: pll_rst_seq

Overview:
- Reset/lock supervisor in the board reference-clock domain, directly upstream of the PLL wrapper.
- Drives the PLL `rst` input and watches its `locked` output.
- Produces the system reset that is later re-synchronised into the PLL output-clock domain, plus status.
- Guarantees a PLL reset pulse after power-on and after any lock timeout; holds the system reset until lock has been stable for a programmed time.

Parameters:
- STABLE_CYCLES, 50000, refclk cycles lock must stay continuously high before the hold phase (1 ms at 50 MHz).
- HOLD_CYCLES, 16, extra refclk cycles sys_rst stays asserted after lock is qualified.
- PLL_RST_CYCLES, 32, width of each PLL reset pulse in refclk cycles (>=1).
- RELOCK_TIMEOUT, 500000, refclk cycles allowed in WAIT_LOCK before forcing a new PLL reset.
- CNT_W, 8, width of the lock-loss counter.

Ports:
- refclk  in  1  board reference clock (50 MHz); the only clock.
- rst  in  1  synchronous, active-high reset, sampled on refclk.
- pll_locked  in  1  PLL lock indicator, asynchronous to refclk.
- pll_rst  out  1  reset to PLL, active-high, registered.
- sys_rst  out  1  system reset request, active-high, registered.
- ready  out  1  high only in RUN; equals ~sys_rst.
- lock_loss_cnt  out  CNT_W  number of RUN->WAIT_LOCK transitions; saturates at all-ones.
- state_o  out  3  encoded state: PLL_RST=0, WAIT_LOCK=1, STABLE=2, HOLD=3, RUN=4.

Behaviour:
- Single refclk domain. rst is synchronous, active-high. All outputs are registered.
- pll_locked passes through a 2-flop synchroniser to give locked_s. Synchroniser flops reset to 0.
- While rst=1:
  - state=PLL_RST, cnt=0, pll_rst=1, sys_rst=1, ready=0, lock_loss_cnt=0, synchroniser=0.
  - rst asserted mid-operation aborts any state on the next edge.
- One shared down/up counter cnt, wide enough for max(STABLE_CYCLES, RELOCK_TIMEOUT). It clears on every state change.
- PLL_RST:
  - pll_rst=1, sys_rst=1.
  - After PLL_RST_CYCLES cycles in this state -> WAIT_LOCK. pll_rst falls on the same edge.
  - locked_s is ignored here.
- WAIT_LOCK:
  - pll_rst=0, sys_rst=1.
  - locked_s=1 -> STABLE.
  - Else, when cnt reaches RELOCK_TIMEOUT-1 -> PLL_RST.
  - If both hold in the same cycle, locked_s wins.
- STABLE:
  - sys_rst=1.
  - locked_s=0 -> WAIT_LOCK; the timeout restarts from 0.
  - cnt reaching STABLE_CYCLES-1 with locked_s=1 -> HOLD.
- HOLD:
  - sys_rst=1.
  - locked_s=0 -> WAIT_LOCK.
  - After HOLD_CYCLES cycles -> RUN.
- RUN:
  - sys_rst=0, ready=1.
  - locked_s=0 -> WAIT_LOCK. sys_rst=1 and ready=0 take effect on that same edge. lock_loss_cnt increments by 1, saturating at 2^CNT_W-1.
- Lock-drop precedence: a single-cycle lock drop in STABLE, HOLD or RUN always restarts qualification. There is no glitch filter beyond the synchroniser.
- Latency from PLL_RST exit: if pll_locked is first sampled high at edge T and stays high, STABLE is entered at T+2. sys_rst falls at edge T+2+STABLE_CYCLES+HOLD_CYCLES.
- lock_loss_cnt counts only RUN exits. Drops in STABLE or HOLD are not counted.
- state_o is encoded 0..4; codes 5..7 are illegal. Any illegal state -> PLL_RST next edge with sys_rst=1.

Test Plan:
Bench parameters: STABLE=8, HOLD=4, PLL_RST=4, TIMEOUT=64, CNT_W=2.
- Power-on: rst high 3 cycles then low, pll_locked=0 -> pll_rst=1 for exactly 4 edges after rst release, then 0; sys_rst stays 1, state_o=1.
- Clean lock: pll_locked rises and is first sampled at edge T -> state_o=2 at T+2, 3 at T+10, 4 and sys_rst=0 at T+14; ready mirrors ~sys_rst.
- Unstable lock: pll_locked high 5 cycles, low 1 cycle, then high -> state returns to WAIT_LOCK and sys_rst never falls before 14 edges after the final rise; lock_loss_cnt=0.
- No lock: pll_locked held 0 -> after 64 edges in WAIT_LOCK, pll_rst re-asserts for 4 cycles; this repeats every 68 cycles; sys_rst=1 throughout.
- Lock loss in RUN repeated 5 times, relocking each time -> sys_rst rises 2 edges after each fall of pll_locked; lock_loss_cnt goes 1, 2, 3, 3, 3 (saturates).
- rst pulsed for 1 cycle while in RUN -> next edge: state_o=0, pll_rst=1, sys_rst=1, lock_loss_cnt=0.

Source files
------------

// File: rtl/pll_rst_seq.sv
// pll_rst_seq: PLL reset/lock supervisor in the refclk domain; pulses the PLL reset and
// holds the system reset until lock has been continuously qualified.
module pll_rst_seq #(
  parameter int STABLE_CYCLES  = 50000,
  parameter int HOLD_CYCLES    = 16,
  parameter int PLL_RST_CYCLES = 32,
  parameter int RELOCK_TIMEOUT = 500000,
  parameter int CNT_W          = 8
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             pll_locked,
  output logic             pll_rst,
  output logic             sys_rst,
  output logic             ready,
  output logic [CNT_W-1:0] lock_loss_cnt,
  output logic [2:0]       state_o
);
  localparam int M1 = STABLE_CYCLES > RELOCK_TIMEOUT ? STABLE_CYCLES : RELOCK_TIMEOUT;
  localparam int M2 = HOLD_CYCLES > PLL_RST_CYCLES ? HOLD_CYCLES : PLL_RST_CYCLES;
  localparam int CW = $clog2((M1 > M2 ? M1 : M2) + 1);
  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_HOLD      = 3'd3,
    S_RUN       = 3'd4
  } state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt, cnt_n;
  logic sync_a, locked_s;
  always_comb begin
    nxt = state;
    case (state)
      S_PLL_RST:   nxt = cnt == CW'(PLL_RST_CYCLES - 1) ? S_WAIT_LOCK : S_PLL_RST;
      S_WAIT_LOCK: nxt = locked_s ? S_STABLE : cnt == CW'(RELOCK_TIMEOUT - 1) ? S_PLL_RST : S_WAIT_LOCK;
      S_STABLE:    nxt = !locked_s ? S_WAIT_LOCK : cnt == CW'(STABLE_CYCLES - 1) ? S_HOLD : S_STABLE;
      S_HOLD:      nxt = !locked_s ? S_WAIT_LOCK : cnt == CW'(HOLD_CYCLES - 1) ? S_RUN : S_HOLD;
      S_RUN:       nxt = locked_s ? S_RUN : S_WAIT_LOCK;
      default:     nxt = S_PLL_RST;
    endcase
    // RUN has no time limit, so the counter is parked there instead of wrapping
    cnt_n = (nxt != state || state == S_RUN) ? '0 : cnt + CW'(1);
  end
  always_ff @(posedge refclk) begin
    if (rst) begin
      sync_a        <= 1'b0;
      locked_s      <= 1'b0;
      state         <= S_PLL_RST;
      cnt           <= '0;
      pll_rst       <= 1'b1;
      sys_rst       <= 1'b1;
      ready         <= 1'b0;
      lock_loss_cnt <= '0;
    end else begin
      sync_a   <= pll_locked;
      locked_s <= sync_a;
      state    <= nxt;
      cnt      <= cnt_n;
      pll_rst  <= nxt == S_PLL_RST;
      sys_rst  <= nxt != S_RUN;
      ready    <= nxt == S_RUN;
      if (state == S_RUN && nxt == S_WAIT_LOCK && !(&lock_loss_cnt))
        lock_loss_cnt <= lock_loss_cnt + CNT_W'(1);
    end
  end
  assign state_o = state;
endmodule
